// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit with architectural HI/LO.
//   Executes multu/mult (shift-add) and divu/div (restoring), one bit per
//   cycle, plus mthi/mtlo writes. Latency is WIDTH+1 edges from the start edge.
// Build option: define MDU_DIV_EN to include the divider. Without it, divide
//   ops complete immediately as a no-op with a single done pulse.
// Ports:
//   clk, reset (async, active-low)
//   start, op[1:0] (00 multu, 01 mult, 10 divu, 11 div), a, b  - issue
//   flush                                                       - abort
//   hi_wr, lo_wr, wdata                                         - mthi/mtlo
//   busy, done, hi, lo, div_zero                                - status/result
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
`ifdef MDU_DIV_EN
  localparam logic [1:0] DIV  = 2'd2;
`endif
  localparam logic [1:0] FIX  = 2'd3;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] prod;   // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   mcand;  // multiplicand or divisor magnitude
  logic               sign_a;
  logic               sign_b;
`ifdef MDU_DIV_EN
  logic               is_div;
  logic               b_zero;
`else
  logic               nop_pend;
`endif

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] mul_res;
  logic               last;

  assign busy  = (state != IDLE);
  assign last  = (cnt == CW'(WIDTH - 1));
  assign abs_a = (op[0] && a[WIDTH-1]) ? -a : a;
  assign abs_b = (op[0] && b[WIDTH-1]) ? -b : b;

  // Shift-add step: conditional add into the upper half, then shift right.
  assign mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
  assign mul_next = {mul_sum, prod[WIDTH-1:1]};
  assign mul_res  = (sign_a ^ sign_b) ? -prod : prod;

`ifdef MDU_DIV_EN
  logic [WIDTH:0]     div_part;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   div_lo;
  logic [WIDTH-1:0]   div_hi;

  // Restoring step: shift the next dividend bit into the remainder, try to
  // subtract the divisor, and shift the resulting quotient bit in at the LSB.
  assign div_part = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
  assign div_diff = div_part - {1'b0, mcand};
  assign div_next = div_diff[WIDTH] ? {div_part[WIDTH-1:0], prod[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};

  assign quo    = prod[WIDTH-1:0];
  assign rem    = prod[2*WIDTH-1:WIDTH];
  // With divisor 0 the remainder ends up as |a|; the dividend-sign fix then
  // restores the original a, so HI needs no special case.
  assign div_lo = b_zero ? '1 : ((sign_a ^ sign_b) ? -quo : quo);
  assign div_hi = sign_a ? -rem : rem;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      prod     <= '0;
      mcand    <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
`ifdef MDU_DIV_EN
      is_div   <= 1'b0;
      b_zero   <= 1'b0;
`else
      nop_pend <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_wr) hi <= wdata;
          if (lo_wr) lo <= wdata;
`ifndef MDU_DIV_EN
          done     <= nop_pend;
          nop_pend <= 1'b0;
`endif
          if (start && !flush) begin
            div_zero <= 1'b0;
            cnt      <= '0;
            sign_a   <= op[0] & a[WIDTH-1];
            sign_b   <= op[0] & b[WIDTH-1];
`ifdef MDU_DIV_EN
            is_div   <= op[1];
            b_zero   <= (b == '0);
            if (op[1]) begin
              mcand <= abs_b;
              prod  <= {{WIDTH{1'b0}}, abs_a};
              state <= DIV;
            end else begin
              mcand <= abs_a;
              prod  <= {{WIDTH{1'b0}}, abs_b};
              state <= MUL;
            end
`else
            if (op[1]) begin
              nop_pend <= 1'b1;
            end else begin
              mcand <= abs_a;
              prod  <= {{WIDTH{1'b0}}, abs_b};
              state <= MUL;
            end
`endif
          end
        end
        MUL: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            prod <= mul_next;
            cnt  <= cnt + 1'b1;
            if (last) state <= FIX;
          end
        end
`ifdef MDU_DIV_EN
        DIV: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            prod <= div_next;
            cnt  <= cnt + 1'b1;
            if (last) state <= FIX;
          end
        end
`endif
        FIX: begin
          if (flush) begin
            state <= IDLE;
          end else begin
`ifdef MDU_DIV_EN
            if (is_div) begin
              hi       <= div_hi;
              lo       <= div_lo;
              div_zero <= b_zero;
            end else begin
              hi <= mul_res[2*WIDTH-1:WIDTH];
              lo <= mul_res[WIDTH-1:0];
            end
`else
            hi <= mul_res[2*WIDTH-1:WIDTH];
            lo <= mul_res[WIDTH-1:0];
`endif
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit (WIDTH=32).
//   Issued operations push the expected HI/LO/div_zero and completion cycle;
//   a monitor pops and compares on every done pulse. Follows MDU_DIV_EN.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, flush, hi_wr, lo_wr;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .hi_wr(hi_wr), .lo_wr(lo_wr), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           at;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int e0 = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic         m_dz = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("hi", 64'(hi), 64'(e.hi));
        chk("lo", 64'(lo), 64'(e.lo));
        chk("div_zero", 64'(div_zero), 64'(e.dz));
        chk("done_cycle", 64'(cyc), 64'(e.at));
      end
    end
  end

  // Reference: plain arithmetic on the architectural state. Returns the
  // number of edges from the start edge to the done-setting edge.
  function automatic int model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0] p;
    longint sx, sy, q, r;
    case (o)
      2'd0: begin
        p = {32'b0, x} * {32'b0, y};
        m_hi = p[63:32]; m_lo = p[31:0]; m_dz = 1'b0;
        return W + 1;
      end
      2'd1: begin
        p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
        m_hi = p[63:32]; m_lo = p[31:0]; m_dz = 1'b0;
        return W + 1;
      end
      default: begin
        if (!DIV_EN) begin
          m_dz = 1'b0;
          return 1;
        end
        if (y == '0) begin
          m_lo = '1; m_hi = x; m_dz = 1'b1;
        end else if (o == 2'd2) begin
          m_lo = x / y; m_hi = x % y; m_dz = 1'b0;
        end else begin
          sx = longint'($signed(x)); sy = longint'($signed(y));
          q = sx / sy; r = sx % sy;
          m_lo = q[31:0]; m_hi = r[31:0]; m_dz = 1'b0;
        end
        return W + 1;
      end
    endcase
  endfunction

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit wh, input bit wl, input logic [W-1:0] wd, input bit push,
                       output int bexp);
    exp_t e;
    int lat;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; hi_wr = wh; lo_wr = wl; wdata = wd;
    @(posedge clk); #1;
    start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
    e0 = cyc;
    if (wh) m_hi = wd;
    if (wl) m_lo = wd;
    bexp = (o[1] && !DIV_EN) ? 0 : W + 1;
    if (push) begin
      lat = model(o, x, y);
      e.hi = m_hi; e.lo = m_lo; e.dz = m_dz; e.at = e0 + lat;
      exp_q.push_back(e);
    end
  endtask

  // Waits for the scoreboard to drain, counting busy cycles; with noise set,
  // fires mthi/mtlo while busy, which must have no effect.
  task automatic wait_done(input int bexp, input bit noise);
    int bc = 0;
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
      if (busy === 1'b1) bc++;
      if (noise && busy === 1'b1) begin
        hi_wr = 1'($urandom_range(0, 1)); lo_wr = 1'($urandom_range(0, 1)); wdata = $urandom;
      end else begin
        hi_wr = 1'b0; lo_wr = 1'b0;
      end
    end
    hi_wr = 1'b0; lo_wr = 1'b0;
    if (exp_q.size() > 0) begin
      chk("timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    chk("busy_cycles", 64'(bc), 64'(bexp));
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit wh, input bit wl, input logic [W-1:0] wd, input bit noise);
    int bexp;
    issue(o, x, y, wh, wl, wd, 1'b1, bexp);
    wait_done(bexp, noise);
  endtask

  task automatic mthi(input logic [W-1:0] wd);
    @(negedge clk); hi_wr = 1'b1; wdata = wd;
    @(posedge clk); #1; hi_wr = 1'b0;
    m_hi = wd;
    chk("mthi", 64'(hi), 64'(m_hi));
  endtask

  task automatic mtlo(input logic [W-1:0] wd);
    @(negedge clk); lo_wr = 1'b1; wdata = wd;
    @(posedge clk); #1; lo_wr = 1'b0;
    m_lo = wd;
    chk("mtlo", 64'(lo), 64'(m_lo));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'd1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bexp;
    logic [1:0] ro;
    reset = 1'b0; start = 1'b0; flush = 1'b0; op = 2'd0;
    a = '0; b = '0; wdata = '1; hi_wr = 1'b1; lo_wr = 1'b1;

    // Reset state, with HI/LO writes held active that must be ignored.
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_div_zero", 64'(div_zero), 64'd0);
    hi_wr = 1'b0; lo_wr = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);

    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, '0, 0);
    run_op(2'd1, 32'hFFFF_FFFD, 32'd7, 0, 0, '0, 0);
    mthi(32'h1234_5678);
    mtlo(32'h9ABC_DEF0);
    run_op(2'd3, 32'hFFFF_FFF9, 32'd2, 0, 0, '0, 0);
    run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, '0, 0);
    run_op(2'd2, 32'd5, 32'd0, 0, 0, '0, 0);
    issue(2'd0, 32'd2, 32'd3, 0, 0, '0, 1'b1, bexp);
    chk("dz_cleared_at_e0", 64'(div_zero), 64'd0);
    wait_done(bexp, 0);

    // Flush mid-operation: HI/LO keep preloaded values, no done.
    mthi(32'hA);
    mtlo(32'hB);
    issue(2'd0, 32'd3, 32'd4, 0, 0, '0, 1'b0, bexp);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_done", 64'(done), 64'd0);
    chk("flush_hi", 64'(hi), 64'(m_hi));
    chk("flush_lo", 64'(lo), 64'(m_lo));
    chk("flush_div_zero", 64'(div_zero), 64'd0);
    repeat (40) @(negedge clk);
    chk("flush_hi_later", 64'(hi), 64'(m_hi));
    chk("flush_lo_later", 64'(lo), 64'(m_lo));

    // start together with flush in IDLE: nothing issues.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'd0; a = 32'd3; b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("start_flush_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    chk("start_flush_busy_later", 64'(busy), 64'd0);
    chk("start_flush_lo", 64'(lo), 64'(m_lo));

    // Asynchronous reset in the middle of an operation.
    issue(DIV_EN ? 2'd3 : 2'd1, 32'hFFFF_FFF9, 32'd2, 0, 0, '0, 1'b0, bexp);
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("areset_busy", 64'(busy), 64'd0);
    chk("areset_done", 64'(done), 64'd0);
    chk("areset_hi", 64'(hi), 64'd0);
    chk("areset_lo", 64'(lo), 64'd0);
    chk("areset_div_zero", 64'(div_zero), 64'd0);
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    run_op(2'd0, 32'd6, 32'd7, 0, 0, '0, 0);

    // Randomized operations with same-cycle and while-busy HI/LO writes.
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      run_op(ro, pick(), pick(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
             $urandom, 1'b1);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Parametrised iterative multiply/divide unit for the pipelined MIPS core. It executes `mult`/`multu`/`div`/`divu` over multiple cycles, holds the architectural HI/LO registers, and serves `mthi`/`mtlo`. It sits beside the ALU in EX. Its `busy` output feeds the hazard logic, which stalls IF/ID/EX while an operation is in flight. `flush` lets a taken branch abort an operation issued from the wrong path.

## Interface
- `WIDTH`, default 32: operand/HI/LO width; must be even and ≥4.
- `clk`  in  1  core clock (slow_clk domain).
- `reset`  in  1  asynchronous, active-low.
- `start`  in  1  issue strobe, one cycle, sampled only in IDLE.
- `op`  in  2  00 multu, 01 mult, 10 divu, 11 div; sampled with `start`.
- `a`  in  WIDTH  multiplicand / dividend.
- `b`  in  WIDTH  multiplier / divisor.
- `flush`  in  1  abort current operation / suppress same-cycle `start`.
- `hi_wr`, `lo_wr`  in  1  `mthi`/`mtlo` write enables.
- `wdata`  in  WIDTH  `mthi`/`mtlo` data.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle completion pulse.
- `hi`, `lo`  out  WIDTH  architectural HI/LO.
- `div_zero`  out  1  last completed divide had divisor 0.

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE: on `start & ~flush`, latch |a|, |b| and the sign bits (signed ops only), clear the iteration counter and `div_zero`, and go to MUL (op 0x) or DIV (op 1x).
- MUL: shift-add, one multiplier bit per cycle. After WIDTH cycles go to FIX.
- DIV: restoring, one quotient bit per cycle. After WIDTH cycles go to FIX.
- FIX: apply sign correction and write HI/LO. Go to IDLE.
- Arithmetic rules:
  - Signed product is negated when the operand signs differ.
  - Quotient is negated when the signs differ.
  - Remainder takes the dividend's sign.
  - Internal product is 2·WIDTH bits.
  - Negation is two's complement mod 2^WIDTH.
- Divisor 0: LO = all ones, HI = `a` unmodified (no sign fix), `div_zero` = 1. The operation still takes full latency.
- Signed MIN / −1: LO = MIN, HI = 0. This falls out of the rules above and raises no flag.
- `hi_wr`/`lo_wr` in IDLE write `wdata` at the clock edge, including in the same cycle as `start`. The operation result later overwrites them. They are ignored while `busy`.
- `start` while `busy` is ignored.
- `flush` while busy: return to IDLE at the next edge with no `done` pulse. HI/LO keep their pre-operation values and `div_zero` stays 0.
- `flush` and `start` in the same IDLE cycle: no operation starts.

## Timing
- Reset: `busy`=0, `done`=0, `hi`=0, `lo`=0, `div_zero`=0, state IDLE. Reset asserted mid-operation returns all outputs to these values immediately, asynchronously.
- Let edge E0 be the edge that samples `start`.
- `busy` is 1 from E0 until edge E0+WIDTH+1.
- HI/LO are updated at edge E0+WIDTH+1, and `busy` falls at that same edge.
- `done` is high for the single cycle after E0+WIDTH+1. A new `start` is accepted in that cycle.
- Total latency is WIDTH+1 edges (33 for WIDTH=32). Latency is independent of operand values.
- `hi`/`lo` are register outputs with no combinational path from inputs. Forwarding to `mfhi`/`mflo` is the hazard logic's responsibility, gated by `busy`.

## Configuration
- `MDU_DIV_EN` defined: full behaviour as above.
- `MDU_DIV_EN` undefined:
  - The DIV state and divider datapath are not synthesised.
  - `start` with op 1x asserts `done` for one cycle, one edge after E0. `busy` stays 0, HI/LO are unchanged and `div_zero` stays 0.
  - Multiply behaviour is identical in both builds.

## Test plan
All scenarios use WIDTH=32.

- multu a=0xFFFFFFFF, b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; `done` pulses in the cycle after edge E0+33; `busy` high for exactly 33 cycles.
- mult a=0xFFFFFFFD (−3), b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (−21). Then `mthi` with `wdata`=0x12345678 -> `hi`=0x12345678 at the next edge.
- div a=0xFFFFFFF9 (−7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. div a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0, `div_zero`=0.
- divu a=5, b=0 -> LO=0xFFFFFFFF, HI=5, `div_zero`=1. The next `start` clears `div_zero` at its E0.
- Preload HI=0xA, LO=0xB; start multu 3×4; assert `flush` at E0+10 -> `busy`=0 after that edge, no `done`, HI=0xA, LO=0xB. A `start` in the same cycle as `flush` in IDLE -> `busy` stays 0.
- Drive `reset` low at E0+5 of a div -> all outputs 0 immediately. After release, a fresh multu 6×7 gives LO=42.
